// File: rtl/seg_scan_ctrl.sv
// Two-digit seven-segment scan controller: shares one active-low segment bus between
// two digits with blanking gaps, and applies newly loaded BCD pairs only at frame starts.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] dig1_in,
    input  logic [3:0] dig2_in,
    output logic       ready,
    output logic [7:0] seg,
    output logic [1:0] an,
    output logic       frame_tick,
    output logic       err
);

    localparam int unsigned MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {SHOW1, BLANK1, SHOW2, BLANK2} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       act1, act2, sh1, sh2;
    logic [3:0]       act1_nxt, act2_nxt, sh1_nxt, sh2_nxt;
    logic             pending, pending_nxt;
    logic             enter_show1;
    logic [7:0]       seg_nxt;
    logic [1:0]       an_nxt;

    // BCD to active-low segments; non-decimal values show a dash
    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 8'hC0;
            4'd1:    enc = 8'hF9;
            4'd2:    enc = 8'hA4;
            4'd3:    enc = 8'hB0;
            4'd4:    enc = 8'h99;
            4'd5:    enc = 8'h92;
            4'd6:    enc = 8'h82;
            4'd7:    enc = 8'hF8;
            4'd8:    enc = 8'h80;
            4'd9:    enc = 8'h90;
            default: enc = 8'hBF;
        endcase
    endfunction

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt - 1'b1;
        act1_nxt    = act1;
        act2_nxt    = act2;
        sh1_nxt     = sh1;
        sh2_nxt     = sh2;
        pending_nxt = pending;
        seg_nxt     = 8'hFF;
        an_nxt      = 2'b11;
        enter_show1 = (state == BLANK2) && (cnt == '0);

        if (cnt == '0) begin
            case (state)
                SHOW1:   begin state_nxt = BLANK1; cnt_nxt = BLANK_LOAD; end
                BLANK1:  begin state_nxt = SHOW2;  cnt_nxt = SHOW_LOAD;  end
                SHOW2:   begin state_nxt = BLANK2; cnt_nxt = BLANK_LOAD; end
                default: begin state_nxt = SHOW1;  cnt_nxt = SHOW_LOAD;  end
            endcase
        end

        // A load on the frame boundary bypasses the shadow pair
        if (enter_show1) begin
            if (load) begin
                act1_nxt = dig1_in;
                act2_nxt = dig2_in;
            end else if (pending) begin
                act1_nxt = sh1;
                act2_nxt = sh2;
            end
            pending_nxt = 1'b0;
        end else if (load) begin
            sh1_nxt     = dig1_in;
            sh2_nxt     = dig2_in;
            pending_nxt = 1'b1;
        end

        case (state_nxt)
            SHOW1: begin an_nxt = 2'b10; seg_nxt = enc(act1_nxt); end
            SHOW2: begin an_nxt = 2'b01; seg_nxt = enc(act2_nxt); end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK2;
            cnt        <= BLANK_LOAD;
            act1       <= '0;
            act2       <= '0;
            sh1        <= '0;
            sh2        <= '0;
            pending    <= 1'b0;
            ready      <= 1'b1;
            seg        <= 8'hFF;
            an         <= 2'b11;
            frame_tick <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            act1       <= act1_nxt;
            act2       <= act2_nxt;
            sh1        <= sh1_nxt;
            sh2        <= sh2_nxt;
            pending    <= pending_nxt;
            ready      <= ~pending_nxt;
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= enter_show1;
            err        <= (act1_nxt > 4'd9) || (act2_nxt > 4'd9);
        end
    end

endmodule
